// File: rtl/multi_channel_delay_unit.sv
// ---------------------------------------------------------------------------
// multi_channel_delay_unit
//
// Purpose:
//   CHANNELS independent ready/valid lanes, each an elastic pipeline of DEPTH
//   stages. Unstalled, an item leaves exactly DEPTH cycles after it was
//   accepted; under backpressure the lane stalls and bubbles collapse, with
//   no drops or duplicates. MODE selects the input-to-lane routing at ingress:
//   straight (input i -> lane i) or reversed (input i -> lane CHANNELS-1-i).
//
// Ports:
//   CLK           clock, all state updates on the rising edge
//   RESET         synchronous, active-high reset
//   MODE          0 = straight routing, 1 = reversed routing
//   INPUT_data    CHANNELS*WIDTH, channel i in [i*WIDTH +: WIDTH]
//   INPUT_valid   per-channel valid
//   INPUT_ready   per-channel ready (forced low during RESET)
//   OUTPUT_data   CHANNELS*WIDTH, lane k in [k*WIDTH +: WIDTH]
//   OUTPUT_valid  per-lane valid
//   OUTPUT_ready  per-lane ready
//   COUNT         CHANNELS*CW, lane k occupancy in [k*CW +: CW]
//   IDLE          high when every lane is empty
// ---------------------------------------------------------------------------
module multi_channel_delay_unit #(
    parameter  int WIDTH    = 5,
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 3,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      MODE,
    input  logic [CHANNELS*WIDTH-1:0] INPUT_data,
    input  logic [CHANNELS-1:0]       INPUT_valid,
    output logic [CHANNELS-1:0]       INPUT_ready,
    output logic [CHANNELS*WIDTH-1:0] OUTPUT_data,
    output logic [CHANNELS-1:0]       OUTPUT_valid,
    input  logic [CHANNELS-1:0]       OUTPUT_ready,
    output logic [CHANNELS*CW-1:0]    COUNT,
    output logic                      IDLE
);

    logic [CHANNELS-1:0] w_stage0_rdy;
    logic [CHANNELS-1:0] w_lane_idle;

    for (genvar gk = 0; gk < CHANNELS; gk++) begin : g_lane
        // The routing is an involution, so the source feeding lane k under
        // reversed mode is the same index that input k would be sent to.
        localparam int SRC_REV = CHANNELS - 1 - gk;

        logic [DEPTH-1:0] r_valid;
        logic [WIDTH-1:0] r_data [DEPTH];
        logic [CW-1:0]    r_count;
        logic [DEPTH-1:0] w_rdy;
        logic             w_in_valid;
        logic [WIDTH-1:0] w_in_data;
        logic             w_accept;
        logic             w_drain;

        assign w_in_valid = MODE ? INPUT_valid[SRC_REV] : INPUT_valid[gk];
        assign w_in_data  = MODE ? INPUT_data[SRC_REV*WIDTH +: WIDTH]
                                 : INPUT_data[gk*WIDTH +: WIDTH];

        // ready(s) = OUTPUT_ready | ~valid(s) | ... | ~valid(DEPTH-1).
        // Unrolled as a running AND of the valids from the tail so the
        // chain never reads its own output.
        always_comb begin : p_ready
            logic w_tail_full;
            w_tail_full = 1'b1;
            w_rdy       = '0;
            for (int s = DEPTH - 1; s >= 0; s--) begin
                w_tail_full = w_tail_full & r_valid[s];
                w_rdy[s]    = OUTPUT_ready[gk] | ~w_tail_full;
            end
        end

        assign w_accept = w_in_valid & w_rdy[0];
        assign w_drain  = r_valid[DEPTH-1] & OUTPUT_ready[gk];

        always_ff @(posedge CLK) begin
            if (RESET) begin
                r_valid <= '0;
                for (int s = 0; s < DEPTH; s++) begin
                    r_data[s] <= '0;
                end
                r_count <= '0;
            end else begin
                if (w_rdy[0]) begin
                    r_valid[0] <= w_in_valid;
                    r_data[0]  <= w_in_data;
                end
                for (int s = 1; s < DEPTH; s++) begin
                    if (w_rdy[s]) begin
                        r_valid[s] <= r_valid[s-1];
                        r_data[s]  <= r_data[s-1];
                    end
                end
                if (w_accept && !w_drain) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_accept && w_drain) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end

        assign w_stage0_rdy[gk]              = w_rdy[0];
        assign w_lane_idle[gk]               = (r_count == '0);
        // Masked during RESET so the flush cycle presents no valid item.
        assign OUTPUT_valid[gk]              = r_valid[DEPTH-1] & ~RESET;
        assign OUTPUT_data[gk*WIDTH +: WIDTH] = r_data[DEPTH-1];
        assign COUNT[gk*CW +: CW]            = r_count;
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ingress
        assign INPUT_ready[gi] = ~RESET &
                                 (MODE ? w_stage0_rdy[CHANNELS-1-gi] : w_stage0_rdy[gi]);
    end

    assign IDLE = &w_lane_idle;

endmodule
